// File: rtl/fold_sig_acc_if.sv
// Handshake and signature bus between the fold stage, the signature accumulator and its consumer.
// Optional FOLD_SIG_CMP_EN adds the registered sig_a==sig_b flag (match).
interface fold_sig_acc_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] aa;
  logic [15:0] bb;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sig_a;
  logic [15:0] sig_b;
`ifdef FOLD_SIG_CMP_EN
  logic        match;

  modport master (
    output in_valid, aa, bb, out_ready,
    input  in_ready, out_valid, sig_a, sig_b, match
  );

  modport slave (
    input  in_valid, aa, bb, out_ready,
    output in_ready, out_valid, sig_a, sig_b, match
  );
`else
  modport master (
    output in_valid, aa, bb, out_ready,
    input  in_ready, out_valid, sig_a, sig_b
  );

  modport slave (
    input  in_valid, aa, bb, out_ready,
    output in_ready, out_valid, sig_a, sig_b
  );
`endif
endinterface

// File: rtl/fold_sig_acc.sv
// Dual 16-bit MISR signature accumulator over LEN folded aa/bb word pairs per frame.
// Define FOLD_SIG_CMP_EN to build the registered sig_a==sig_b comparator (match).
module fold_sig_acc #(
  parameter int unsigned LEN = 8
) (
  input logic           clk,
  input logic           rst,
  fold_sig_acc_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LEN_C = CNT_W'(LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      sig_a_q, sig_a_d;
  logic [15:0]      sig_b_q, sig_b_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;

  // x^16+x^15+x^13+x^4+1 shift with the new word folded in.
  function automatic logic [15:0] misr_step(input logic [15:0] sig, input logic [15:0] din);
    logic fb;
    fb = sig[15] ^ sig[14] ^ sig[12] ^ sig[3];
    return {sig[14:0], fb} ^ din;
  endfunction

  assign accept  = bus.in_valid && in_ready_q;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sig_a_d     = sig_a_q;
    sig_b_d     = sig_b_q;
    case (state_q)
      IDLE: begin
        // Previous frame's signatures stay visible until a new frame starts from a zero seed.
        if (accept) begin
          sig_a_d = misr_step(16'h0000, bus.aa);
          sig_b_d = misr_step(16'h0000, bus.bb);
          cnt_d   = CNT_W'(1);
          state_d = (LEN == 1) ? DONE : ACC;
        end
      end
      ACC: begin
        if (accept) begin
          sig_a_d = misr_step(sig_a_q, bus.aa);
          sig_b_d = misr_step(sig_b_q, bus.bb);
          cnt_d   = cnt_inc;
          if (cnt_inc == LEN_C) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    in_ready_d  = (state_d != DONE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sig_a_q     <= 16'h0000;
      sig_b_q     <= 16'h0000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sig_a_q     <= sig_a_d;
      sig_b_q     <= sig_b_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sig_a     = sig_a_q;
  assign bus.sig_b     = sig_b_q;

`ifdef FOLD_SIG_CMP_EN
  logic match_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q <= 1'b1;
    end else begin
      match_q <= (sig_a_d == sig_b_d);
    end
  end

  assign bus.match = match_q;
`endif

endmodule

// File: tb/tb_fold_sig_acc.sv
// Bench for fold_sig_acc: LEN=1/2 directed frames plus a LEN=8 instance checked every cycle
// against a frame-level signature model; FOLD_SIG_CMP_EN enables match checks.
module tb_fold_sig_acc;

  localparam int M_LEN = 8;

  logic clk = 1'b0;
  logic rst;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fold_sig_acc_if bus1();
  fold_sig_acc_if bus2();
  fold_sig_acc_if bus8();

  fold_sig_acc #(.LEN(1))     dut1 (.clk(clk), .rst(rst), .bus(bus1));
  fold_sig_acc #(.LEN(2))     dut2 (.clk(clk), .rst(rst), .bus(bus2));
  fold_sig_acc #(.LEN(M_LEN)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Signature polynomial x^16+x^15+x^13+x^4+1 applied to one word.
  function automatic logic [15:0] polyStep(input logic [15:0] s, input logic [15:0] w);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15] ^ s[14] ^ s[12] ^ s[3]) r[0] = 1'b1;
    return r ^ w;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame model for the LEN=8 instance: words accepted so far, whether a frame is pending.
  int          mCnt;
  bit          mDone;
  logic [15:0] mSigA;
  logic [15:0] mSigB;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mCnt  = 0;
      mDone = 1'b0;
      mSigA = 16'h0000;
      mSigB = 16'h0000;
    end else if (mDone) begin
      if (bus8.out_ready) begin
        mDone = 1'b0;
        mCnt  = 0;
      end
    end else if (bus8.in_valid) begin
      mSigA = polyStep((mCnt == 0) ? 16'h0000 : mSigA, bus8.aa);
      mSigB = polyStep((mCnt == 0) ? 16'h0000 : mSigB, bus8.bb);
      mCnt++;
      if (mCnt == M_LEN) mDone = 1'b1;
    end
  end

  always @(negedge clk) begin
    checkOutput("m8_out_valid", bus8.out_valid, mDone);
    checkOutput("m8_in_ready", bus8.in_ready, !mDone);
    checkOutput("m8_sig_a", bus8.sig_a, mSigA);
    checkOutput("m8_sig_b", bus8.sig_b, mSigB);
`ifdef FOLD_SIG_CMP_EN
    checkOutput("m8_match", bus8.match, mSigA == mSigB);
`endif
  end

  // One word pair followed by an idle cycle: in_valid toggles every other cycle.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
    bus8.in_valid = 1'b1;
    bus8.aa       = a;
    bus8.bb       = b;
    tick();
    bus8.in_valid = 1'b0;
    tick();
  endtask

  task automatic release8();
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    checkOutput("len8_release_out_valid", bus8.out_valid, 1'b0);
  endtask

  task automatic frame2(input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] expA, input string tag);
    bus2.bb       = 16'h0000;
    bus2.in_valid = 1'b1;
    bus2.aa       = w0;
    tick();
    checkOutput({tag, "_mid_out_valid"}, bus2.out_valid, 1'b0);
    bus2.aa = w1;
    tick();
    bus2.in_valid = 1'b0;
    checkOutput({tag, "_out_valid"}, bus2.out_valid, 1'b1);
    checkOutput({tag, "_sig_a"}, bus2.sig_a, expA);
    checkOutput({tag, "_sig_b"}, bus2.sig_b, 16'h0000);
    bus2.out_ready = 1'b1;
    tick();
    bus2.out_ready = 1'b0;
    checkOutput({tag, "_idle_out_valid"}, bus2.out_valid, 1'b0);
  endtask

  initial begin
    logic [15:0] fa [8];
    logic [15:0] fb [8];

    rst = 1'b1;
    bus1.in_valid = 1'b0; bus1.aa = '0; bus1.bb = '0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.aa = '0; bus2.bb = '0; bus2.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.aa = '0; bus8.bb = '0; bus8.out_ready = 1'b0;

    @(negedge clk);
    #1;
    checkOutput("rst_in_ready", bus1.in_ready, 1'b1);
    checkOutput("rst_out_valid", bus1.out_valid, 1'b0);
    checkOutput("rst_sig_a", bus2.sig_a, 16'h0000);
    checkOutput("rst_sig_b", bus2.sig_b, 16'h0000);
`ifdef FOLD_SIG_CMP_EN
    checkOutput("rst_match", bus1.match, 1'b1);
`endif
    tick();
    rst = 1'b0;
    tick();

    // LEN=1: a single accept completes the frame.
    bus1.in_valid = 1'b1;
    bus1.aa       = 16'h1234;
    bus1.bb       = 16'h1234;
    tick();
    bus1.in_valid = 1'b0;
    checkOutput("len1_out_valid", bus1.out_valid, 1'b1);
    checkOutput("len1_in_ready", bus1.in_ready, 1'b0);
    checkOutput("len1_sig_a", bus1.sig_a, 16'h1234);
    checkOutput("len1_sig_b", bus1.sig_b, 16'h1234);
`ifdef FOLD_SIG_CMP_EN
    checkOutput("len1_match", bus1.match, 1'b1);
`endif
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    checkOutput("len1_idle_out_valid", bus1.out_valid, 1'b0);
    checkOutput("len1_idle_in_ready", bus1.in_ready, 1'b1);
    checkOutput("len1_idle_sig_a_kept", bus1.sig_a, 16'h1234);

    // LEN=2: feedback tap and plain shift.
    frame2(16'h8000, 16'h0000, 16'h0001, "len2_fb");
    frame2(16'h0001, 16'h0000, 16'h0002, "len2_shift");

    // LEN=8 frame A, toggling in_valid; a single 1 walks through the bit-3 tap.
    fa = '{16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    for (int i = 0; i < 8; i++) applyStimulus(fa[i], fa[i]);
    checkOutput("len8_a_out_valid", bus8.out_valid, 1'b1);
    checkOutput("len8_a_sig_a", bus8.sig_a, 16'h0088);
    checkOutput("len8_a_sig_b", bus8.sig_b, 16'h0088);
`ifdef FOLD_SIG_CMP_EN
    checkOutput("len8_a_match", bus8.match, 1'b1);
`endif

    // Back-pressure in DONE with in_valid held high.
    bus8.in_valid = 1'b1;
    bus8.aa       = 16'hFFFF;
    bus8.bb       = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("len8_hold_in_ready", bus8.in_ready, 1'b0);
      checkOutput("len8_hold_sig_a", bus8.sig_a, 16'h0088);
    end
    release8();
    checkOutput("len8_a_idle_sig_a", bus8.sig_a, 16'h0088);

    // Frame B: bb differs from aa in one bit of the fifth word.
    fa = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
    fb = fa;
    fb[4] = fb[4] ^ 16'h0010;
    for (int i = 0; i < 8; i++) applyStimulus(fa[i], fb[i]);
    checkOutput("len8_b_out_valid", bus8.out_valid, 1'b1);
`ifdef FOLD_SIG_CMP_EN
    checkOutput("len8_b_match", bus8.match, 1'b0);
`endif
    release8();

    // Reset after 3 words discards the partial frame.
    for (int i = 0; i < 8; i++) fb[i] = ~fa[i];
    for (int i = 0; i < 3; i++) applyStimulus(fa[i], fb[i]);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_out_valid", bus8.out_valid, 1'b0);
    checkOutput("mid_rst_in_ready", bus8.in_ready, 1'b1);
    checkOutput("mid_rst_sig_a", bus8.sig_a, 16'h0000);
    checkOutput("mid_rst_sig_b", bus8.sig_b, 16'h0000);
`ifdef FOLD_SIG_CMP_EN
    checkOutput("mid_rst_match", bus8.match, 1'b1);
`endif
    tick();
    rst = 1'b0;
    tick();
    checkOutput("post_rst_out_valid", bus8.out_valid, 1'b0);
    for (int i = 0; i < 8; i++) applyStimulus(fa[i], fb[i]);
    checkOutput("len8_c_out_valid", bus8.out_valid, 1'b1);
    release8();

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fold_sig_acc.md
FOLD_SIG_ACC -- requirements
Module: fold_sig_acc

Interface
REQ-001 Parameter: LEN, default 8, number of folded word pairs per signature frame; legal range 1..256.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  aa/bb word pair present.
REQ-006 in_ready  output  1  block accepts a word pair this cycle.
REQ-007 aa  input  16  folded a-word from the upstream 32-to-16 XOR fold stage.
REQ-008 bb  input  16  folded b-word from the same fold stage, same cycle as aa.
REQ-009 out_valid  output  1  frame signatures are valid.
REQ-010 out_ready  input  1  downstream accepts the signatures.
REQ-011 sig_a  output  16  MISR signature of the aa stream for the frame.
REQ-012 sig_b  output  16  MISR signature of the bb stream for the frame.
REQ-013 match  output  1  sig_a equals sig_b; port exists only with FOLD_SIG_CMP_EN.

Function
REQ-014 States SHALL be IDLE, ACC and DONE, registered and encoded in 2 bits.
REQ-015 in_ready SHALL be 1 in IDLE and ACC and 0 in DONE; out_valid SHALL be 1 only in DONE.
REQ-016 A word is accepted only when in_valid and in_ready are both 1 on a rising edge.
REQ-017 MISR update per accepted word: sig_next = {sig[14:0], fb} XOR din, with fb = sig[15]^sig[14]^sig[12]^sig[3] (x^16+x^15+x^13+x^4+1).
REQ-018 In IDLE, sig_a and sig_b SHALL be treated as seed 16'h0000, so the first accepted word loads sig = din.
REQ-019 A frame counter SHALL count accepted words from 0; it clears to 0 on entry to IDLE.
REQ-020 IDLE->ACC on an accept when LEN>1; IDLE->DONE on an accept when LEN==1.
REQ-021 ACC->DONE on the accept that makes the count equal to LEN; ACC holds otherwise, and sig is held on cycles with no accept.
REQ-022 DONE->IDLE when out_ready is 1; sig_a and sig_b SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 In the DONE->IDLE cycle no input is accepted, because in_ready=0; the next frame starts no earlier than the following cycle.
REQ-024 sig_a and sig_b SHALL remain readable in IDLE until the next frame's first accept overwrites them.
REQ-025 Latency: out_valid asserts exactly one cycle after the LEN-th accept edge.
REQ-026 in_ready, out_valid and match SHALL be driven from registers or state decode only, with no combinational path from in_valid or out_ready.

Reset
REQ-027 rst=1 SHALL force IDLE, counter=0, sig_a=sig_b=16'h0000, out_valid=0, in_ready=1 and match=1 (when present), immediately and asynchronously.
REQ-028 Reset asserted mid-frame or in DONE SHALL discard the partial or pending frame; release resumes in IDLE with no spurious out_valid.

Configuration
REQ-029 Macro FOLD_SIG_CMP_EN: when defined, port match and a registered comparator are built, and match = (sig_a==sig_b), updated alongside sig.
REQ-030 Without FOLD_SIG_CMP_EN, the port and the comparator logic SHALL be absent; all other behaviour is identical.

Verification
REQ-031 LEN=1: accept aa=16'h1234, bb=16'h1234 -> next cycle out_valid=1, sig_a=sig_b=16'h1234, match=1.
REQ-032 LEN=2: aa=16'h8000 then 16'h0000 -> sig_a=16'h0001. aa=16'h0001 then 16'h0000 -> sig_a=16'h0002.
REQ-033 LEN=8 with in_valid toggling every other cycle -> out_valid asserts exactly one cycle after the 8th accept; no accepts are lost or double-counted.
REQ-034 In DONE, hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, signatures stable; out_ready=1 -> IDLE next cycle.
REQ-035 Assert rst after 3 of 8 words -> all outputs return to reset values; a fresh 8-word frame then produces the same signature as a standalone run.
REQ-036 FOLD_SIG_CMP_EN: aa and bb streams differing in one bit of word 5 -> match=0 at DONE.
